// File: rtl/add_1bit.sv
// ----------------------------------------------------------------------------
// add_1bit
//
// Registered single-bit full adder. Each accepted cycle adds a, b and an
// effective carry-in, and presents sum / c_out one clock later. It can be
// used as a pipelined full-adder cell. When carry feedback is compiled in,
// it works as an LSB-first bit-serial adder.
//
// Build option:
//   ADD_1BIT_SERIAL_EN  defined   : the carry register feeds back. The
//                                   effective carry-in is c_in on a 'first'
//                                   bit and the stored carry on later bits.
//                       undefined : no carry register. The effective
//                                   carry-in is always c_in, and 'first'
//                                   only affects bit_cnt.
//
// Parameters:
//   CNT_W      width of bit_cnt (legal range 1..16)
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset (has priority over in_valid)
//   in_valid   a / b / c_in / first are accepted this cycle
//   a, b       operand bits
//   c_in       external carry-in
//   first      marks the LSB of a serial word
//   sum        registered sum bit
//   c_out      registered carry-out bit
//   out_valid  one-cycle pulse: sum / c_out were updated by this cycle's edge
//   bit_cnt    bits accepted since the last 'first' (saturating)
//
// Handshake: in_valid qualifies the inputs and there is no backpressure, so
// every cycle with in_valid=1 is accepted. out_valid is high for exactly one
// cycle, one clock after acceptance. sum / c_out / bit_cnt then hold until the
// next accepted bit, so the consumer must sample them on the out_valid cycle.
// ----------------------------------------------------------------------------
module add_1bit #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             a,
  input  logic             b,
  input  logic             c_in,
  input  logic             first,
  output logic             sum,
  output logic             c_out,
  output logic             out_valid,
  output logic [CNT_W-1:0] bit_cnt
);

  logic             sum_q, sum_d;
  logic             c_out_q, c_out_d;
  logic             out_valid_q, out_valid_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             ci;
  logic             cnt_at_max;

`ifdef ADD_1BIT_SERIAL_EN
  logic             carry_q, carry_d;
`endif

  // Effective carry-in. A 'first' bit always restarts the word from c_in.
  always_comb begin
`ifdef ADD_1BIT_SERIAL_EN
    ci = first ? c_in : carry_q;
`else
    ci = c_in;
`endif
  end

  // The counter saturates rather than wrapping, so long words still read as
  // "at least this many bits".
  assign cnt_at_max = (bit_cnt_q == {CNT_W{1'b1}});

  always_comb begin
    sum_d       = sum_q;
    c_out_d     = c_out_q;
    out_valid_d = 1'b0;
    bit_cnt_d   = bit_cnt_q;
`ifdef ADD_1BIT_SERIAL_EN
    carry_d     = carry_q;
`endif
    if (in_valid) begin
      sum_d       = a ^ b ^ ci;
      c_out_d     = (a & b) | (a & ci) | (b & ci);
      out_valid_d = 1'b1;
`ifdef ADD_1BIT_SERIAL_EN
      carry_d     = (a & b) | (a & ci) | (b & ci);
`endif
      if (first) begin
        bit_cnt_d = CNT_W'(1);
      end else if (!cnt_at_max) begin
        bit_cnt_d = bit_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q       <= 1'b0;
      c_out_q     <= 1'b0;
      out_valid_q <= 1'b0;
      bit_cnt_q   <= '0;
`ifdef ADD_1BIT_SERIAL_EN
      carry_q     <= 1'b0;
`endif
    end else begin
      sum_q       <= sum_d;
      c_out_q     <= c_out_d;
      out_valid_q <= out_valid_d;
      bit_cnt_q   <= bit_cnt_d;
`ifdef ADD_1BIT_SERIAL_EN
      carry_q     <= carry_d;
`endif
    end
  end

  assign sum       = sum_q;
  assign c_out     = c_out_q;
  assign out_valid = out_valid_q;
  assign bit_cnt   = bit_cnt_q;

endmodule

// File: tb/tb_add_1bit.sv
// ----------------------------------------------------------------------------
// tb_add_1bit
//
// Two instances share every input: the default CNT_W=6 build, and a CNT_W=2
// build so that counter saturation shows up after only a few bits. The driver
// pushes the expected response word {sum, c_out, cnt6, cnt2} for each
// accepted bit. The monitor pops an entry on every out_valid. On quiet cycles
// it checks that the outputs hold their last values.
// ----------------------------------------------------------------------------
module tb_add_1bit;

  localparam int W = 10;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       in_valid = 1'b0;
  logic       a = 1'b0, b = 1'b0, c_in = 1'b0, first = 1'b0;
  logic       sum, c_out, out_valid;
  logic [5:0] bit_cnt;
  logic       sum2, c_out2, out_valid2;
  logic [1:0] bit_cnt2;

  add_1bit #(.CNT_W(6)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .c_in(c_in),
    .first(first), .sum(sum), .c_out(c_out), .out_valid(out_valid),
    .bit_cnt(bit_cnt)
  );

  add_1bit #(.CNT_W(2)) u_dut_w2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .c_in(c_in),
    .first(first), .sum(sum2), .c_out(c_out2), .out_valid(out_valid2),
    .bit_cnt(bit_cnt2)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] last_exp = '0;
  int n_checks = 0;
  int n_errors = 0;

  // Reference model state, kept as plain integers.
  int m_carry = 0;
  int m_cnt6  = 0;
  int m_cnt2  = 0;

`ifdef ADD_1BIT_SERIAL_EN
  localparam bit SERIAL = 1'b1;
`else
  localparam bit SERIAL = 1'b0;
`endif

  task automatic check_word(input string name, input logic [W-1:0] e);
    logic [W-1:0] got;
    got = {sum, c_out, bit_cnt, bit_cnt2};
    n_checks++;
    if (got !== e || sum2 !== e[9] || c_out2 !== e[8]) begin
      n_errors++;
      $display("FAIL %s t=%0t got sum=%b c_out=%b cnt=%0d cnt2=%0d (w2 sum=%b c_out=%b) exp sum=%b c_out=%b cnt=%0d cnt2=%0d",
               name, $time, sum, c_out, bit_cnt, bit_cnt2, sum2, c_out2,
               e[9], e[8], e[7:2], e[1:0]);
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rst) begin
      last_exp = '0;
    end else begin
      n_checks++;
      if (out_valid2 !== out_valid) begin
        n_errors++;
        $display("FAIL out_valid_pair t=%0t got w6=%b w2=%b exp equal", $time, out_valid, out_valid2);
      end
      if (out_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_out t=%0t got out_valid=1 exp out_valid=0", $time);
        end else begin
          last_exp = exp_q.pop_front();
          check_word("out", last_exp);
        end
      end else begin
        check_word("hold", last_exp);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v, input logic ta, input logic tb,
                       input logic tc, input logic tf);
    int ci, total, lim6, lim2;
    @(posedge clk);
    #1;
    in_valid = v; a = ta; b = tb; c_in = tc; first = tf;
    if (v) begin
      ci    = (SERIAL && !tf) ? m_carry : int'(tc);
      total = int'(ta) + int'(tb) + ci;
      m_carry = total / 2;
      lim6 = (1 << 6) - 1;
      lim2 = (1 << 2) - 1;
      if (tf) begin
        m_cnt6 = 1;
        m_cnt2 = 1;
      end else begin
        m_cnt6 = (m_cnt6 + 1 > lim6) ? lim6 : m_cnt6 + 1;
        m_cnt2 = (m_cnt2 + 1 > lim2) ? lim2 : m_cnt2 + 1;
      end
      exp_q.push_back({1'(total % 2), 1'(total / 2), 6'(m_cnt6), 2'(m_cnt2)});
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Reset while in_valid=1 with all-ones operands; the reset must win.
  task automatic apply_reset();
    idle(2);
    @(posedge clk);
    #1;
    rst = 1'b1; in_valid = 1'b1; a = 1'b1; b = 1'b1; c_in = 1'b1; first = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0; in_valid = 1'b0;
    m_carry = 0; m_cnt6 = 0; m_cnt2 = 0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    idle(2);

    apply_reset();
    idle(2);

    // Truth table, first=1, c_in=0, back to back.
    drive(1, 0, 0, 0, 1);
    drive(1, 0, 1, 0, 1);
    drive(1, 1, 0, 0, 1);
    drive(1, 1, 1, 0, 1);
    // External carry-in.
    drive(1, 1, 1, 1, 1);
    drive(1, 0, 0, 1, 1);
    idle(1);

    // 3 + 1 LSB-first over three bits.
    drive(1, 1, 1, 0, 1);
    drive(1, 1, 0, 0, 0);
    drive(1, 0, 0, 0, 0);

    // Hold for 5 quiet cycles.
    idle(5);

    // Saturation of the 2-bit counter: 1 first bit plus 4 more.
    drive(1, 1, 0, 0, 1);
    for (int i = 0; i < 4; i++) drive(1, 0, 1, 0, 0);
    idle(1);

    // A carry-producing bit followed by a zero bit without 'first'.
    drive(1, 1, 1, 0, 1);
    drive(1, 0, 0, 0, 0);
    idle(2);

    // After reset, a word without 'first' starts from a zero carry.
    drive(1, 1, 1, 0, 1);
    apply_reset();
    drive(1, 0, 1, 0, 0);
    drive(1, 1, 1, 1, 0);
    idle(1);

    // Long word: bit_cnt saturates at 63.
    drive(1, 1, 0, 0, 1);
    for (int i = 0; i < 70; i++) drive(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
    idle(2);

    // Random traffic with gaps and occasional word restarts.
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 4) == 0));
    end
    idle(3);

    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain got pending=%0d exp pending=0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
